// File: rtl/lbus_master.sv
// ============================================================================
//  Module   : lbus_master
//  Purpose  : Local-bus initiator. It sequences single-word read and write
//             cycles on a multiplexed address/data bus and generates the
//             target-side reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lbus_master #(
  parameter int ADDR_SETUP = 1,
  parameter int WR_LOW     = 2,
  parameter int RD_LOW     = 3,
  parameter int RECOVER    = 1,
  parameter int RST_LEN    = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic        tgt_rst_req,
  output logic        busy,
  output logic [15:0] lbus_do,
  input  logic [15:0] lbus_di,
  output logic        lbus_wrn,
  output logic        lbus_rdn,
  output logic        lbus_rstn_o
);

  // A zero-length phase would collapse the bus timing, so every phase lasts at least one cycle.
  localparam int c_AS_N  = (ADDR_SETUP < 1) ? 1 : ADDR_SETUP;
  localparam int c_WR_N  = (WR_LOW     < 1) ? 1 : WR_LOW;
  localparam int c_RD_N  = (RD_LOW     < 1) ? 1 : RD_LOW;
  localparam int c_REC_N = (RECOVER    < 1) ? 1 : RECOVER;
  localparam int c_RST_N = (RST_LEN    < 1) ? 1 : RST_LEN;

  localparam logic [7:0] c_AS_LAST  = 8'(c_AS_N  - 1);
  localparam logic [7:0] c_WR_LAST  = 8'(c_WR_N  - 1);
  localparam logic [7:0] c_RD_LAST  = 8'(c_RD_N  - 1);
  localparam logic [7:0] c_REC_LAST = 8'(c_REC_N - 1);
  localparam logic [7:0] c_RST_LAST = 8'(c_RST_N - 1);

  typedef enum logic [2:0] {
    S_TRST  = 3'd0,
    S_IDLE  = 3'd1,
    S_ADDR  = 3'd2,
    S_WSTB  = 3'd3,
    S_RSTB  = 3'd4,
    S_RECOV = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_wr;
  logic [15:0] r_wdata;

  assign cmd_ready = (r_state == S_IDLE) && !tgt_rst_req;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_TRST;
      r_cnt       <= 8'd0;
      r_wr        <= 1'b0;
      r_wdata     <= 16'h0000;
      lbus_rstn_o <= 1'b0;
      lbus_wrn    <= 1'b1;
      lbus_rdn    <= 1'b1;
      lbus_do     <= 16'h0000;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'h0000;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_TRST: begin
          lbus_rstn_o <= 1'b0;
          lbus_wrn    <= 1'b1;
          lbus_rdn    <= 1'b1;
          if (r_cnt == c_RST_LAST) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            lbus_rstn_o <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        // A target-reset request beats a pending command, which then waits in place.
        S_IDLE: begin
          if (tgt_rst_req) begin
            r_state     <= S_TRST;
            r_cnt       <= 8'd0;
            lbus_rstn_o <= 1'b0;
          end else if (cmd_valid) begin
            r_state <= S_ADDR;
            r_cnt   <= 8'd0;
            r_wr    <= cmd_wr;
            r_wdata <= cmd_wdata;
            lbus_do <= cmd_addr;
          end
        end

        S_ADDR: begin
          if (r_cnt == c_AS_LAST) begin
            r_cnt <= 8'd0;
            if (r_wr) begin
              r_state  <= S_WSTB;
              lbus_do  <= r_wdata;
              lbus_wrn <= 1'b0;
            end else begin
              r_state  <= S_RSTB;
              lbus_rdn <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_WSTB: begin
          if (r_cnt == c_WR_LAST) begin
            r_state  <= S_RECOV;
            r_cnt    <= 8'd0;
            lbus_wrn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        // Read data is captured on the same edge that releases the strobe.
        S_RSTB: begin
          if (r_cnt == c_RD_LAST) begin
            r_state   <= S_RECOV;
            r_cnt     <= 8'd0;
            lbus_rdn  <= 1'b1;
            rsp_rdata <= lbus_di;
            rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RECOV: begin
          if (r_cnt == c_REC_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state     <= S_TRST;
          r_cnt       <= 8'd0;
          lbus_rstn_o <= 1'b0;
          lbus_wrn    <= 1'b1;
          lbus_rdn    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbus_master.sv
// ============================================================================
//  Module   : tb_lbus_master
//  Purpose  : Self-checking bench for lbus_master with a read-data scoreboard
//             and a continuous bus-protocol monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lbus_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        tgt_rst_req;
  logic        busy;
  logic [15:0] lbus_do;
  wire  [15:0] lbus_di;
  logic        lbus_wrn;
  logic        lbus_rdn;
  logic        lbus_rstn_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] sb[$];
  logic [15:0] wqa[$];
  logic [15:0] wqd[$];

  logic        prev_wrn = 1'b1;
  logic        prev_rdn = 1'b1;
  logic [15:0] prev_do  = 16'h0000;

  always #5 clk = ~clk;

  lbus_master dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .tgt_rst_req (tgt_rst_req),
    .busy        (busy),
    .lbus_do     (lbus_do),
    .lbus_di     (lbus_di),
    .lbus_wrn    (lbus_wrn),
    .lbus_rdn    (lbus_rdn),
    .lbus_rstn_o (lbus_rstn_o)
  );

  // Target model: returns address-dependent data only while the read strobe is low.
  function automatic logic [15:0] rd_value(input logic [15:0] a);
    return (a == 16'h0180) ? 16'hBEEF : ((a ^ 16'h5A5A) + 16'h0101);
  endfunction

  assign lbus_di = lbus_rdn ? 16'hDEAD : rd_value(lbus_do);

  always @(negedge clk) begin
    if (rstn) begin
      total++;
      if (!lbus_wrn && !lbus_rdn) begin
        bad++;
        $display("FAIL strobe_overlap wrn=%b rdn=%b required not both 0", lbus_wrn, lbus_rdn);
      end
      total++;
      if ((!lbus_wrn && !prev_rdn) || (!lbus_rdn && !prev_wrn)) begin
        bad++;
        $display("FAIL strobe_gap wrn=%b rdn=%b prev_wrn=%b prev_rdn=%b required idle cycle between strobes",
                 lbus_wrn, lbus_rdn, prev_wrn, prev_rdn);
      end
      if ((!lbus_wrn && !prev_wrn) || (!lbus_rdn && !prev_rdn)) begin
        total++;
        if (lbus_do !== prev_do) begin
          bad++;
          $display("FAIL do_stable do=%h required %h", lbus_do, prev_do);
        end
      end
      if (!lbus_wrn && prev_wrn) begin
        total++;
        if (wqa.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected do=%h required no write strobe", lbus_do);
        end else begin
          if (lbus_do !== wqd[0] || prev_do !== wqa[0]) begin
            bad++;
            $display("FAIL wr_bus data=%h addr=%h required data=%h addr=%h",
                     lbus_do, prev_do, wqd[0], wqa[0]);
          end
          wqa.delete(0);
          wqd.delete(0);
        end
      end
      if (rsp_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected rdata=%h required no rsp_valid", rsp_rdata);
        end else begin
          if (rsp_rdata !== sb[0]) begin
            bad++;
            $display("FAIL rsp_data rdata=%h required %h", rsp_rdata, sb[0]);
          end
          sb.delete(0);
        end
      end
    end
    prev_wrn <= lbus_wrn;
    prev_rdn <= lbus_rdn;
    prev_do  <= lbus_do;
  end

  // Drives one command from a negedge, waits for the handshake and returns on the negedge of the first busy cycle.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    n         = 0;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    #1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout rdy=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (wr) begin
        wqa.push_back(a);
        wqd.push_back(d);
      end else begin
        sb.push_back(rd_value(a));
      end
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_timeout rdy=%b required 1", cmd_ready);
    end
  endtask

  // Counts low cycles of lbus_rstn_o starting at the current point; leaves off on the first high sample.
  task automatic trst_count(output int cnt, output bit strobes_hi, output bit do_zero, output bit rdy_lo);
    cnt        = 0;
    strobes_hi = 1'b1;
    do_zero    = 1'b1;
    rdy_lo     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (lbus_rstn_o !== 1'b0) break;
      cnt++;
      if (lbus_wrn !== 1'b1 || lbus_rdn !== 1'b1) strobes_hi = 1'b0;
      if (lbus_do !== 16'h0000) do_zero = 1'b0;
      if (cmd_ready !== 1'b0) rdy_lo = 1'b0;
    end
  endtask

  task automatic test_reset;
    int cnt;
    bit sh, dz, rl;
    rstn        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = 16'h0000;
    cmd_wdata   = 16'h0000;
    tgt_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({lbus_rstn_o, lbus_wrn, lbus_rdn, rsp_valid, lbus_do, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0}) begin
      bad++;
      $display("FAIL reset_values rstn_o=%b wrn=%b rdn=%b rv=%b do=%h rdata=%h required 0 1 1 0 0000 0000",
               lbus_rstn_o, lbus_wrn, lbus_rdn, rsp_valid, lbus_do, rsp_rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    trst_count(cnt, sh, dz, rl);
    total++;
    if (cnt != 16) begin
      bad++;
      $display("FAIL reset_trst_len cycles=%0d required 16", cnt);
    end
    total++;
    if (!sh || !dz || !rl) begin
      bad++;
      $display("FAIL reset_trst_outputs strobes_hi=%b do_zero=%b rdy_lo=%b required 1 1 1", sh, dz, rl);
    end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_idle rdy=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    logic [15:0] e_do[4]  = '{16'h0100, 16'h1234, 16'h1234, 16'h1234};
    logic        e_wrn[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    wait_idle;
    issue(1'b1, 16'h0100, 16'h1234);
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge clk);
      total++;
      if ({lbus_do, lbus_wrn, lbus_rdn, cmd_ready} !== {e_do[t], e_wrn[t], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL write_t%0d do=%h wrn=%b rdn=%b rdy=%b required do=%h wrn=%b rdn=1 rdy=0",
                 t + 1, lbus_do, lbus_wrn, lbus_rdn, cmd_ready, e_do[t], e_wrn[t]);
      end
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_ready_t5 rdy=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_read;
    logic e_rdn[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic e_rv[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    wait_idle;
    issue(1'b0, 16'h0180, 16'h0000);
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      total++;
      if ({lbus_do, lbus_wrn, lbus_rdn, rsp_valid, cmd_ready} !== {16'h0180, 1'b1, e_rdn[t], e_rv[t], 1'b0}) begin
        bad++;
        $display("FAIL read_t%0d do=%h wrn=%b rdn=%b rv=%b rdy=%b required do=0180 wrn=1 rdn=%b rv=%b rdy=0",
                 t + 1, lbus_do, lbus_wrn, lbus_rdn, rsp_valid, cmd_ready, e_rdn[t], e_rv[t]);
      end
    end
    total++;
    if (rsp_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL read_rdata rdata=%h required beef", rsp_rdata);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL read_t6 rv=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
    end
    issue(1'b1, 16'h0200, 16'h5555);
    wait_idle;
    total++;
    if (rsp_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL read_hold rdata=%h required beef", rsp_rdata);
    end
  endtask

  task automatic test_rst_req;
    int cnt;
    bit sh, dz, rl;
    wait_idle;
    cmd_wr      = 1'b1;
    cmd_addr    = 16'h0300;
    cmd_wdata   = 16'hA0A0;
    cmd_valid   = 1'b1;
    tgt_rst_req = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstreq_ready rdy=%b required 0", cmd_ready);
    end
    @(negedge clk);
    tgt_rst_req = 1'b0;
    trst_count(cnt, sh, dz, rl);
    total++;
    if (cnt != 16 || !sh || !rl) begin
      bad++;
      $display("FAIL rstreq_trst cycles=%0d strobes_hi=%b rdy_lo=%b required 16 1 1", cnt, sh, rl);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstreq_first_idle rdy=%b required 1", cmd_ready);
    end
    @(posedge clk);
    wqa.push_back(16'h0300);
    wqd.push_back(16'hA0A0);
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || lbus_do !== 16'h0300 || lbus_wrn !== 1'b1) begin
      bad++;
      $display("FAIL rstreq_accept busy=%b do=%h wrn=%b required 1 0300 1", busy, lbus_do, lbus_wrn);
    end
    wait_idle;
  endtask

  task automatic test_async_reset;
    int cnt;
    bit sh, dz, rl;
    wait_idle;
    issue(1'b0, 16'h0042, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #2;
    total++;
    if (lbus_rdn !== 1'b0) begin
      bad++;
      $display("FAIL arst_in_rstb rdn=%b required 0", lbus_rdn);
    end
    rstn = 1'b0;
    #1;
    sb.delete();
    total++;
    if ({lbus_rdn, lbus_wrn, lbus_rstn_o, rsp_valid, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL arst_async rdn=%b wrn=%b rstn_o=%b rv=%b rdata=%h required 1 1 0 0 0000",
               lbus_rdn, lbus_wrn, lbus_rstn_o, rsp_valid, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    trst_count(cnt, sh, dz, rl);
    total++;
    if (cnt != 16 || !sh || !dz || !rl) begin
      bad++;
      $display("FAIL arst_trst cycles=%0d strobes_hi=%b do_zero=%b rdy_lo=%b required 16 1 1 1", cnt, sh, dz, rl);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_first_idle rdy=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_random;
    wait_idle;
    for (int k = 0; k < 1000; k++) begin
      issue(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle;
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0 || wqa.size() != 0) begin
      bad++;
      $display("FAIL random_drain reads_left=%0d writes_left=%0d required 0 0", sb.size(), wqa.size());
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_rst_req;
    test_async_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
